// File: rtl/alu_op_sequencer.sv
// Command front-end and result capture for the add/sub/compare datapath.
// Latches {op, a, b}, holds them for SETTLE_CYC cycles, then captures mux_y for the response port.
module alu_op_sequencer #(
  parameter int WIDTH      = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [1:0]       sel,
  input  logic [WIDTH-1:0] mux_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       rsp_op,
  output logic             rsp_zero,
  output logic             rsp_err
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    RESP   = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept, capture, rsv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    capture   = 1'b0;
    rsv       = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept = 1'b1;
          // Reserved op skips the datapath entirely and answers with an error.
          if (cmd_op == 2'b11) begin
            rsv       = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = SETTLE;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      cmd_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RESP);
    end
  end

  // Operands and select stay put until the next accepted command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
      sel  <= 2'b00;
    end else if (accept) begin
      op_a <= cmd_a;
      op_b <= cmd_b;
      sel  <= cmd_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_op   <= 2'b00;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (rsv) begin
      rsp_data <= '0;
      rsp_op   <= 2'b11;
      rsp_zero <= 1'b1;
      rsp_err  <= 1'b1;
    end else if (capture) begin
      rsp_data <= mux_y;
      rsp_op   <= sel;
      rsp_zero <= (mux_y == '0);
      rsp_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance with SETTLE_CYC=1 driving a
// modelled result mux, one with SETTLE_CYC=3 whose mux_y is driven directly.
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst_n;

  logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_zero, rsp_err;
  logic [1:0] cmd_op, sel, rsp_op;
  logic [3:0] cmd_a, cmd_b, op_a, op_b, mux_y, rsp_data;

  logic       c3_valid, c3_ready, r3_valid, r3_ready, r3_zero, r3_err;
  logic [1:0] c3_op, sel3, r3_op;
  logic [3:0] c3_a, c3_b, op_a3, op_b3, mux3, r3_data;

  int n_chk;
  int n_fail;

  alu_op_sequencer #(.WIDTH(4), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .op_a(op_a), .op_b(op_b), .sel(sel), .mux_y(mux_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_op(rsp_op), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  alu_op_sequencer #(.WIDTH(4), .SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_op(c3_op),
    .cmd_a(c3_a), .cmd_b(c3_b),
    .op_a(op_a3), .op_b(op_b3), .sel(sel3), .mux_y(mux3),
    .rsp_valid(r3_valid), .rsp_ready(r3_ready), .rsp_data(r3_data),
    .rsp_op(r3_op), .rsp_zero(r3_zero), .rsp_err(r3_err)
  );

  // Datapath model: add, sub, compare (a<b), reserved returns all ones.
  always_comb begin
    mux_y = 4'hF;
    case (sel)
      2'b00: mux_y = op_a + op_b;
      2'b01: mux_y = op_a - op_b;
      2'b10: mux_y = {3'b000, (op_a < op_b)};
      default: mux_y = 4'hF;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; rsp_ready = 0;
    c3_valid = 0; c3_op = 0; c3_a = 0; c3_b = 0; r3_ready = 0; mux3 = 0;

    // Power-on reset
    step(); step();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_sel", sel, 0);
    check("rst_op_a", op_a, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    rst_n = 1'b1;
    #1;
    check("rel_cmd_ready_before_edge", cmd_ready, 0);
    step();
    check("rel_cmd_ready_after_edge", cmd_ready, 1);
    check("rel_cmd_ready3", c3_ready, 1);

    // Add 3+4
    cmd_valid = 1; cmd_op = 2'b00; cmd_a = 4'd3; cmd_b = 4'd4; rsp_ready = 1;
    step();
    cmd_valid = 0;
    check("add_cmd_ready_low", cmd_ready, 0);
    check("add_op_a", op_a, 3);
    check("add_op_b", op_b, 4);
    check("add_valid_not_yet", rsp_valid, 0);
    step();
    check("add_rsp_valid", rsp_valid, 1);
    check("add_rsp_data", rsp_data, 7);
    check("add_rsp_zero", rsp_zero, 0);
    check("add_rsp_op", rsp_op, 0);
    check("add_rsp_err", rsp_err, 0);
    step();
    check("add_done_valid", rsp_valid, 0);
    check("add_done_ready", cmd_ready, 1);
    check("add_data_hold", rsp_data, 7);

    // Sub 5-5 with backpressure; a command offered during RESP must be ignored
    rsp_ready = 0;
    cmd_valid = 1; cmd_op = 2'b01; cmd_a = 4'd5; cmd_b = 4'd5;
    step();
    cmd_op = 2'b00; cmd_a = 4'd1; cmd_b = 4'd1;
    step();
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_rsp_data", rsp_data, 0);
    check("bp_rsp_zero", rsp_zero, 1);
    check("bp_rsp_op", rsp_op, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_data", rsp_data, 0);
      check("bp_hold_cmd_ready", cmd_ready, 0);
      check("bp_hold_op_a", op_a, 5);
    end
    cmd_valid = 0; rsp_ready = 1;
    step();
    check("bp_release_valid", rsp_valid, 0);
    check("bp_release_ready", cmd_ready, 1);
    check("bp_no_queued_sel", sel, 1);

    // Reserved op: mux_y (0xF) must not reach rsp_data
    rsp_ready = 0;
    cmd_valid = 1; cmd_op = 2'b11; cmd_a = 4'd9; cmd_b = 4'd2;
    step();
    cmd_valid = 0;
    check("rsv_rsp_valid", rsp_valid, 1);
    check("rsv_rsp_err", rsp_err, 1);
    check("rsv_rsp_data", rsp_data, 0);
    check("rsv_rsp_zero", rsp_zero, 1);
    check("rsv_rsp_op", rsp_op, 3);
    check("rsv_sel", sel, 3);
    rsp_ready = 1;
    step();
    check("rsv_done_valid", rsp_valid, 0);
    check("rsv_err_hold", rsp_err, 1);
    check("rsv_done_ready", cmd_ready, 1);

    // Back-to-back: cmd_valid held high across three commands
    cmd_valid = 1; cmd_op = 2'b00; cmd_a = 4'd2; cmd_b = 4'd5;
    step();
    check("b2b0_op_a", op_a, 2);
    check("b2b0_sel", sel, 0);
    check("b2b0_cmd_ready", cmd_ready, 0);
    cmd_op = 2'b01; cmd_a = 4'd3; cmd_b = 4'd5;
    step();
    check("b2b0_valid", rsp_valid, 1);
    check("b2b0_data", rsp_data, 7);
    step();
    check("b2b0_gap_valid", rsp_valid, 0);
    check("b2b0_gap_ready", cmd_ready, 1);
    check("b2b0_gap_op_a", op_a, 2);
    step();
    check("b2b1_op_a", op_a, 3);
    check("b2b1_sel", sel, 1);
    cmd_op = 2'b10; cmd_a = 4'd2; cmd_b = 4'd9;
    step();
    check("b2b1_data", rsp_data, 4'hE);
    check("b2b1_op", rsp_op, 1);
    step();
    check("b2b1_gap_ready", cmd_ready, 1);
    step();
    check("b2b2_op_a", op_a, 2);
    check("b2b2_op_b", op_b, 9);
    check("b2b2_sel", sel, 2);
    cmd_valid = 0;
    step();
    check("b2b2_data", rsp_data, 1);
    check("b2b2_op", rsp_op, 2);
    check("b2b2_zero", rsp_zero, 0);
    step();
    check("b2b2_done_valid", rsp_valid, 0);
    step();
    check("b2b_idle_ready", cmd_ready, 1);
    check("b2b_idle_sel_hold", sel, 2);
    check("b2b_no_extra", rsp_valid, 0);

    // SETTLE_CYC=3: mux_y changes every cycle, only the t0+3 value is captured
    c3_valid = 1; c3_op = 2'b10; c3_a = 4'd1; c3_b = 4'd2; mux3 = 4'h0;
    step();
    c3_valid = 0; mux3 = 4'h1;
    check("s3_cmd_ready_low", c3_ready, 0);
    check("s3_sel", sel3, 2);
    step();
    mux3 = 4'h2;
    check("s3_t1_valid", r3_valid, 0);
    step();
    mux3 = 4'hA;
    check("s3_t2_valid", r3_valid, 0);
    step();
    mux3 = 4'h5;
    check("s3_valid", r3_valid, 1);
    check("s3_data", r3_data, 4'hA);
    check("s3_op", r3_op, 2);
    check("s3_zero", r3_zero, 0);
    check("s3_err", r3_err, 0);
    step();
    check("s3_hold_data", r3_data, 4'hA);
    check("s3_hold_valid", r3_valid, 1);
    r3_ready = 1;
    step();
    check("s3_done_valid", r3_valid, 0);
    check("s3_done_data", r3_data, 4'hA);

    // Reset mid-operation: dut in RESP, dut3 in SETTLE
    r3_ready = 0; rsp_ready = 0;
    cmd_valid = 1; cmd_op = 2'b00; cmd_a = 4'd1; cmd_b = 4'd1;
    c3_valid = 1; c3_op = 2'b00; c3_a = 4'd4; c3_b = 4'd4; mux3 = 4'h8;
    step();
    cmd_valid = 0; c3_valid = 0;
    step();
    check("mid_pre_valid", rsp_valid, 1);
    check("mid_pre_data", rsp_data, 2);
    check("mid_pre_sel3", sel3, 0);
    check("mid_pre_op_a3", op_a3, 4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_data", rsp_data, 0);
    check("mid_rst_ready", cmd_ready, 0);
    check("mid_rst_ready3", c3_ready, 0);
    check("mid_rst_op_a3", op_a3, 0);
    check("mid_rst_valid3", r3_valid, 0);
    step();
    check("mid_rst_held_ready", cmd_ready, 0);
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready3_before", c3_ready, 0);
    step();
    check("mid_rel_ready3", c3_ready, 1);
    check("mid_rel_ready", cmd_ready, 1);
    check("mid_rel_valid3", r3_valid, 0);
    step(); step(); step();
    check("mid_dropped_valid3", r3_valid, 0);
    check("mid_dropped_valid", rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
